// File: rtl/ssram_pkg.sv
// rtl/ssram_pkg.sv - shared SSRAM widths and burst-master state encoding
package ssram_pkg;

  localparam int SSRAM_AW = 15;
  localparam int SSRAM_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } ssram_mst_state_t;

endpackage

// File: rtl/ssram_rd_fifo.sv
// rtl/ssram_rd_fifo.sv - synchronous read-return FIFO for the SSRAM burst master
module ssram_rd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  // Head is masked while empty so stale entries never reach the stream.
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ssram_burst_master.sv
// rtl/ssram_burst_master.sv - command-driven SSRAM burst initiator with write/read streams
// SSRAM_BURST_WRAP_EN: address wraps past 0x7FFF instead of truncating the burst.
module ssram_burst_master
  import ssram_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [SSRAM_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [SSRAM_DW-1:0] wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [SSRAM_DW-1:0] rd_data,
  output logic                done,
  output logic                done_err,
  output logic [SSRAM_AW-1:0] sram_adr_o,
  output logic [SSRAM_DW-1:0] sram_data_o,
  output logic                sram_re_o,
  output logic                sram_we_o,
  input  logic [SSRAM_DW-1:0] sram_data_i
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW:0]          DEPTH_V  = (CW+1)'(FIFO_DEPTH);
  localparam logic [SSRAM_AW-1:0]  ADR_LAST = '1;

  ssram_mst_state_t     state, state_nxt;
  logic [SSRAM_AW-1:0]  addr, addr_nxt;
  logic [LEN_W:0]       remaining, remaining_nxt;
  logic                 inflight;
  logic                 trunc, trunc_nxt;
  logic                 done_nxt, done_err_nxt;
  logic                 fifo_pop, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [CW:0]          used;
  logic                 at_end, more_left;

  ssram_rd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SSRAM_DW)) u_rd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   (sram_data_i),
    .pop   (fifo_pop),
    .dout  (rd_data),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign rd_valid  = ~fifo_empty;
  assign fifo_pop  = rd_valid & rd_ready;
  assign used      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign more_left = (remaining != (LEN_W+1)'(1));

`ifdef SSRAM_BURST_WRAP_EN
  assign at_end = 1'b0;
`else
  assign at_end = (addr == ADR_LAST);
`endif

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    trunc_nxt     = trunc;
    done_nxt      = 1'b0;
    done_err_nxt  = 1'b0;
    cmd_ready     = 1'b0;
    wr_ready      = 1'b0;
    sram_we_o     = 1'b0;
    sram_re_o     = 1'b0;
    sram_adr_o    = '0;
    sram_data_o   = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_nxt      = cmd_addr;
          remaining_nxt = {1'b0, cmd_len} + (LEN_W+1)'(1);
          trunc_nxt     = 1'b0;
          state_nxt     = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready    = 1'b1;
        sram_we_o   = wr_valid;
        sram_adr_o  = addr;
        sram_data_o = wr_data;
        if (wr_valid) begin
          addr_nxt      = addr + SSRAM_AW'(1);
          remaining_nxt = remaining - (LEN_W+1)'(1);
          if (!more_left || at_end) begin
            state_nxt    = IDLE;
            done_nxt     = 1'b1;
            done_err_nxt = at_end & more_left;
          end
        end
      end
      READ: begin
        sram_adr_o = addr;
        // A same-cycle pop frees a slot, so the credit check counts it; this keeps
        // one re per cycle when the consumer never stalls.
        if ((remaining != '0) && (fifo_pop ? (used <= DEPTH_V) : (used < DEPTH_V))) begin
          sram_re_o     = 1'b1;
          addr_nxt      = addr + SSRAM_AW'(1);
          remaining_nxt = remaining - (LEN_W+1)'(1);
          if (!more_left || at_end) begin
            state_nxt = DRAIN;
            trunc_nxt = at_end & more_left;
          end
        end
      end
      DRAIN: begin
        if (!inflight && ((fifo_count == '0) || ((fifo_count == CW'(1)) && fifo_pop))) begin
          state_nxt    = IDLE;
          done_nxt     = 1'b1;
          done_err_nxt = trunc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      trunc     <= 1'b0;
      done      <= 1'b0;
      done_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= remaining_nxt;
      inflight  <= sram_re_o;
      trunc     <= trunc_nxt;
      done      <= done_nxt;
      done_err  <= done_err_nxt;
    end
  end

endmodule

// File: tb/tb_ssram_burst_master.sv
// tb/tb_ssram_burst_master.sv - self-checking bench for ssram_burst_master
module tb_ssram_burst_master;

  localparam int LEN_W      = 8;
  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [14:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        done, done_err;
  logic [14:0] sram_adr_o;
  logic [31:0] sram_data_o;
  logic        sram_re_o, sram_we_o;
  logic [31:0] sram_data_i = '0;

  ssram_burst_master #(.LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .done_err(done_err),
    .sram_adr_o(sram_adr_o), .sram_data_o(sram_data_o),
    .sram_re_o(sram_re_o), .sram_we_o(sram_we_o), .sram_data_i(sram_data_i)
  );

  always #5 clk = ~clk;

  // SSRAM model: unwritten words hold an address-derived pattern.
  logic [31:0] mem    [int];
  logic [31:0] shadow [int];

  function automatic logic [31:0] init_val(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  function automatic logic [31:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] exp_mem(input int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  always @(posedge clk) if (sram_we_o) mem[int'(sram_adr_o)] = sram_data_o;
  always @(posedge clk) sram_data_i <= sram_re_o ? mem_rd(int'(sram_adr_o)) : 32'h0;

  function automatic int model_words(input int a, input int len);
`ifdef SSRAM_BURST_WRAP_EN
    return len + 1;
`else
    return (len + 1 < 32768 - a) ? len + 1 : 32768 - a;
`endif
  endfunction

  int n_vec = 0;
  int n_err = 0;
  logic [14:0] we_adr [$];
  logic [31:0] we_dat [$];
  logic [14:0] re_adr [$];
  logic [31:0] rd_q   [$];
  int  wr_k, done_cnt, both_hi;
  bit  last_err, done_now, s_fire, s_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    we_adr.delete(); we_dat.delete(); re_adr.delete(); rd_q.delete();
    wr_k = 0; done_cnt = 0; both_hi = 0; last_err = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    s_fire   = cmd_valid && cmd_ready;
    s_we     = sram_we_o;
    done_now = done;
    if (sram_we_o) begin we_adr.push_back(sram_adr_o); we_dat.push_back(sram_data_o); end
    if (sram_re_o) re_adr.push_back(sram_adr_o);
    if (sram_we_o && sram_re_o) both_hi++;
    if (wr_valid && wr_ready) wr_k++;
    if (rd_valid && rd_ready) rd_q.push_back(rd_data);
    if (done) begin done_cnt++; last_err = done_err; end
  endtask

  task automatic run_burst(input bit wr, input int a, input int len, input logic [31:0] base,
                           input int wv_pct, input int rr_pct, input int hold,
                           input int exp_n, input bit exp_err);
    bit got_done;
    clear_logs();
    cmd_valid = 1; cmd_write = wr; cmd_addr = 15'(a); cmd_len = 8'(len);
    sample();
    chk("cmd_accept", 32'(s_fire), 1);
    tick();
    cmd_valid = 0;
    got_done = 0;
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      wr_valid = wr && ($urandom_range(99) < wv_pct);
      wr_data  = base + 32'(wr_k);
      rd_ready = (cyc >= hold) && ($urandom_range(99) < rr_pct);
      sample();
      if (!wr && hold >= 3 && cyc == hold - 1) begin
        chk("stall_re_count", re_adr.size(), (exp_n < FIFO_DEPTH) ? exp_n : FIFO_DEPTH);
        chk("stall_pops", rd_q.size(), 0);
      end
      got_done = done_now;
      tick();
    end
    chk("done_seen", 32'(got_done), 1);
    wr_valid = 0; rd_ready = 0;
    sample();
    chk("done_single", done_cnt, 1);
    chk("idle_cmd_ready", 32'(cmd_ready), 1);
    tick();
    chk("done_err", 32'(last_err), 32'(exp_err));
    chk("strobes_exclusive", both_hi, 0);
    if (wr) begin
      chk("we_count", we_adr.size(), exp_n);
      chk("re_in_write", re_adr.size(), 0);
      chk("wr_taken", wr_k, exp_n);
      foreach (we_adr[i]) begin
        chk("we_adr", 32'(we_adr[i]), (a + i) % 32768);
        chk("we_data", we_dat[i], base + 32'(i));
      end
      for (int i = 0; i < exp_n; i++) shadow[(a + i) % 32768] = base + 32'(i);
    end else begin
      chk("re_count", re_adr.size(), exp_n);
      chk("we_in_read", we_adr.size(), 0);
      chk("pop_count", rd_q.size(), exp_n);
      foreach (re_adr[i]) chk("re_adr", 32'(re_adr[i]), (a + i) % 32768);
      foreach (rd_q[i]) chk("rd_data", rd_q[i], exp_mem((a + i) % 32768));
    end
  endtask

  typedef struct {
    bit          wr;
    int          addr;
    int          len;
    logic [31:0] base;
    int          exp_n;
    bit          exp_err;
  } vec_t;

  initial begin
    vec_t tbl [8];
    bit [6:0] pat;
    int fire_cyc, a, len, n;
    bit got, fire_done;

    tbl[0] = '{1'b1, 'h0010, 3, 32'hA0, 4, 1'b0};
    tbl[1] = '{1'b0, 'h0010, 3, 32'h00, 4, 1'b0};
`ifdef SSRAM_BURST_WRAP_EN
    tbl[2] = '{1'b1, 'h7FFE, 3, 32'hB0, 4, 1'b0};
    tbl[3] = '{1'b0, 'h7FFE, 3, 32'h00, 4, 1'b0};
`else
    tbl[2] = '{1'b1, 'h7FFE, 3, 32'hB0, 2, 1'b1};
    tbl[3] = '{1'b0, 'h7FFE, 3, 32'h00, 2, 1'b1};
`endif
    tbl[4] = '{1'b1, 'h0100, 0, 32'hD0, 1, 1'b0};
    tbl[5] = '{1'b0, 'h0100, 0, 32'h00, 1, 1'b0};
    tbl[6] = '{1'b1, 'h7FFF, 0, 32'hE0, 1, 1'b0};
    tbl[7] = '{1'b0, 'h7FFF, 0, 32'h00, 1, 1'b0};

    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0;
    clear_logs();
    repeat (3) tick();
    sample();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", {30'd0, done, done_err}, 0);
    chk("rst_strobes", {30'd0, sram_re_o, sram_we_o}, 0);
    chk("rst_adr", 32'(sram_adr_o), 0);
    chk("rst_wdata", sram_data_o, 0);
    tick();
    rst = 0;

    foreach (tbl[i])
      run_burst(tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].base, 100, 100, 0,
                tbl[i].exp_n, tbl[i].exp_err);

    // consumer stalls six cycles: reads must stop at the FIFO depth
    run_burst(1'b0, 'h0010, 7, 32'h0, 100, 100, 6, 8, 1'b0);

    // reset in the middle of a read burst
    clear_logs();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 15'h0400; cmd_len = 8'd15;
    sample();
    chk("rst_mid_accept", 32'(s_fire), 1);
    tick();
    cmd_valid = 0; rd_ready = 1;
    repeat (4) begin sample(); tick(); end
    rst = 1;
    sample();
    tick();
    rst = 0;
    done_cnt = 0;
    sample();
    chk("rst_mid_strobes", {30'd0, sram_re_o, sram_we_o}, 0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < 5; i++) begin
      chk("rst_mid_rd_valid", 32'(rd_valid), 0);
      tick();
      sample();
    end
    chk("rst_mid_no_done", done_cnt, 0);
    tick();
    rd_ready = 0;

    for (int t = 0; t < 40; t++) begin
      a   = ($urandom_range(3) == 0) ? 'h7FF0 + int'($urandom_range(15)) : int'($urandom_range(32767));
      len = int'($urandom_range(20));
      n   = model_words(a, len);
      run_burst(1'($urandom_range(1)), a, len, $urandom, int'($urandom_range(40, 100)),
                int'($urandom_range(30, 100)), 0, n, n < len + 1);
    end

    // write with gaps while a read command is already held on cmd
    pat = 7'b1011001;
    clear_logs();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 15'h0200; cmd_len = 8'd3;
    sample();
    chk("t6_accept", 32'(s_fire), 1);
    tick();
    cmd_write = 0;
    fire_cyc = -1;
    fire_done = 0;
    for (int cyc = 0; cyc < 40 && fire_cyc < 0; cyc++) begin
      wr_valid = (cyc < 7) ? pat[cyc] : 1'b0;
      wr_data  = 32'hC0 + 32'(wr_k);
      rd_ready = 1;
      sample();
      if (cyc < 7) chk("t6_we", 32'(s_we), 32'(pat[cyc]));
      if (s_fire) begin fire_cyc = cyc; fire_done = done_now; end
      tick();
    end
    wr_valid = 0; cmd_valid = 0;
    chk("t6_cmd2_cycle", fire_cyc, 7);
    chk("t6_cmd2_with_done", 32'(fire_done), 1);
    chk("t6_we_count", we_adr.size(), 4);
    foreach (we_adr[i]) begin
      chk("t6_we_adr", 32'(we_adr[i]), 'h200 + i);
      chk("t6_we_data", we_dat[i], 32'hC0 + 32'(i));
    end
    for (int i = 0; i < 4; i++) shadow['h200 + i] = 32'hC0 + 32'(i);
    got = 0;
    for (int cyc = 0; cyc < 100 && !got; cyc++) begin
      sample();
      got = done_now;
      tick();
    end
    chk("t6_read_done", 32'(got), 1);
    chk("t6_pop_count", rd_q.size(), 4);
    foreach (rd_q[i]) chk("t6_rd_data", rd_q[i], exp_mem('h200 + i));
    chk("t6_done_total", done_cnt, 2);
    rd_ready = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
